// File: rtl/serial_mag_cmp_pkg.sv
// Shared types for the bit-serial magnitude comparator: FSM states,
// comparison results and the per-bit decision helper.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    LT = 2'd0,
    EQ = 2'd1,
    GT = 2'd2
  } result_t;

  // invert flips the sense of a differing pair, used for the sign bit of
  // two's complement operands where a set bit means the smaller value.
  function automatic result_t bit_result(input logic a_bit,
                                         input logic b_bit,
                                         input logic invert);
    result_t res;
    if (a_bit == b_bit) begin
      res = EQ;
    end else if (a_bit ^ invert) begin
      res = GT;
    end else begin
      res = LT;
    end
    return res;
  endfunction

endpackage

// File: rtl/serial_mag_cmp_if.sv
// Operand handshake and LED result bundle of the serial magnitude comparator.
interface serial_mag_cmp_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             out_valid;
  logic             led_r;
  logic             led_g;
  logic             led_b;

  modport master (
    output in_valid, op_a, op_b,
    input  in_ready, out_valid, led_r, led_g, led_b
  );

  modport slave (
    input  in_valid, op_a, op_b,
    output in_ready, out_valid, led_r, led_g, led_b
  );

endinterface

// File: rtl/serial_mag_cmp_rgb_encode.sv
// Combinational map from a comparison result to the {led_r, led_g, led_b}
// pattern: red = A<=B, green = A!=B, blue = A>=B.
module rgb_encode
  import cmp_pkg::*;
(
  input  result_t    res,
  output logic [2:0] rgb
);

  always_comb begin
    rgb = 3'b000;
    case (res)
      LT:      rgb = 3'b110;
      EQ:      rgb = 3'b101;
      GT:      rgb = 3'b011;
      default: rgb = 3'b000;
    endcase
  end

endmodule

// File: rtl/serial_mag_cmp.sv
// Bit-serial MSB-first magnitude comparator with early termination.
// Define CMP_SIGNED_EN to compare the operands as two's complement values.
module serial_mag_cmp
  import cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  serial_mag_cmp_if.slave  bus
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);

`ifdef CMP_SIGNED_EN
  localparam logic SIGNED_EN = 1'b1;
`else
  localparam logic SIGNED_EN = 1'b0;
`endif

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       led_q;
  logic [2:0]       led_d;
  result_t          res_d;
  result_t          bit_res;
  logic             res_load;
  logic             in_ready;
  logic             at_top;

  assign in_ready = (state_q == IDLE) && !rst;
  assign at_top   = (idx_q == IDX_TOP);
  assign bit_res  = bit_result(a_q[idx_q], b_q[idx_q], SIGNED_EN && at_top);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = EQ;
    res_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && in_ready) begin
          a_d     = bus.op_a;
          b_d     = bus.op_b;
          idx_d   = IDX_TOP;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bit_res != EQ) begin
          res_d    = bit_res;
          res_load = 1'b1;
          state_d  = DONE;
        end else if (idx_q == '0) begin
          res_d    = EQ;
          res_load = 1'b1;
          state_d  = DONE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  rgb_encode u_rgb_encode (
    .res (res_d),
    .rgb (led_d)
  );

  // LEDs only change on the edge entering DONE, so a result persists
  // through the following IDLE/RUN cycles until the next one lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= IDX_TOP;
      a_q     <= '0;
      b_q     <= '0;
      led_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      if (res_load) begin
        led_q <= led_d;
      end
    end
  end

  // Outputs are masked by rst so they read idle while reset is held,
  // including the cycle before the first reset edge lands.
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == DONE) && !rst;
  assign bus.led_r     = led_q[2] && !rst;
  assign bus.led_g     = led_q[1] && !rst;
  assign bus.led_b     = led_q[0] && !rst;

endmodule
